// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory port arbiter.
//   state_t : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   gnt_t   : which requester owns the downstream command port
//   CMD_RD / CMD_WR : encoding of the dmem/mem cmd bit
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant picker for the memory port arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> on contention the port that was not granted last wins
//   undefined -> fixed priority, dmem over imem (last_gnt ignored)
// Ports:
//   eligible_i  in  imem has an eligible command
//   eligible_d  in  dmem has an eligible command
//   lock        in  a stalled grant is being held
//   locked_gnt  in  the held grant
//   last_gnt    in  most recently accepted grant
//   gnt         out selected requester
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic eligible_i,
    input  logic eligible_d,
    input  logic lock,
    input  gnt_t locked_gnt,
    input  gnt_t last_gnt,
    output gnt_t gnt
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        gnt = GNT_I;
        if (lock) begin
            gnt = locked_gnt;
        end else if (eligible_i && eligible_d) begin
            // Alternate: whoever was not served last goes first.
            gnt = (last_gnt == GNT_D) ? GNT_I : GNT_D;
        end else if (eligible_d) begin
            gnt = GNT_D;
        end else begin
            gnt = GNT_I;
        end
    end
`else
    logic w_unused_last_gnt;
    assign w_unused_last_gnt = (last_gnt == GNT_D);

    always_comb begin
        gnt = GNT_I;
        if (lock) begin
            gnt = locked_gnt;
        end else if (eligible_d) begin
            gnt = GNT_D;
        end else begin
            gnt = GNT_I;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory controller between the
// core's imem (read-only) and dmem (read/write) ports. The command mux is
// combinational (no added latency); registered state is limited to the
// grant lock, the read owner (FSM) and the last-grant record.
// Optional feature macro: ARB_ROUND_ROBIN_EN (tested only in mem_arb_pick).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   imem_*                     read-only requester (cmd + read return)
//   dmem_*                     read/write requester (cmd + read return + write data)
//   mem_*                      master port to the memory controller
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int p_ADDR_BITS = 32,
    parameter int p_DATA_BITS = 32,
    parameter int p_STRB_BITS = p_DATA_BITS / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    // imem requester
    input  logic [p_ADDR_BITS-1:0] imem_addr,
    input  logic [1:0]             imem_size,
    input  logic                   imem_valid,
    output logic                   imem_ready,
    input  logic                   imem_r_ready,
    output logic                   imem_r_valid,
    output logic [p_DATA_BITS-1:0] imem_r_data,
    output logic                   imem_r_resp,
    // dmem requester
    input  logic [p_ADDR_BITS-1:0] dmem_addr,
    input  logic                   dmem_cmd,
    input  logic [1:0]             dmem_size,
    input  logic                   dmem_valid,
    output logic                   dmem_ready,
    input  logic                   dmem_r_ready,
    output logic                   dmem_r_valid,
    output logic [p_DATA_BITS-1:0] dmem_r_data,
    output logic                   dmem_r_resp,
    input  logic                   dmem_w_valid,
    output logic                   dmem_w_ready,
    input  logic [p_STRB_BITS-1:0] dmem_w_strb,
    input  logic [p_DATA_BITS-1:0] dmem_w_data,
    output logic                   dmem_w_resp,
    // memory controller master port
    output logic [p_ADDR_BITS-1:0] mem_addr,
    output logic                   mem_cmd,
    output logic [1:0]             mem_size,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic                   mem_r_ready,
    input  logic                   mem_r_valid,
    input  logic [p_DATA_BITS-1:0] mem_r_data,
    input  logic                   mem_r_resp,
    output logic                   mem_w_valid,
    input  logic                   mem_w_ready,
    output logic [p_STRB_BITS-1:0] mem_w_strb,
    output logic [p_DATA_BITS-1:0] mem_w_data,
    input  logic                   mem_w_resp
);

    state_t r_state;
    logic   r_lock;
    gnt_t   r_lock_gnt;
    gnt_t   r_last_gnt;

    gnt_t   w_gnt;
    logic   w_run;
    logic   w_idle;
    logic   w_elig_i;
    logic   w_elig_d;
    logic   w_win_elig;
    logic   w_accept;
    logic   w_gnt_d;

    // Write data is accepted together with the command, so the controller's
    // separate write-ready carries no extra information here.
    logic   w_unused_mem_w_ready;
    assign w_unused_mem_w_ready = mem_w_ready;

    assign w_run    = !rst;
    assign w_idle   = (r_state == IDLE);
    assign w_elig_i = imem_valid;
    // A dmem write only competes once its data is presented with it.
    assign w_elig_d = dmem_valid && ((dmem_cmd == CMD_RD) || dmem_w_valid);

    mem_arb_pick u_pick (
        .eligible_i (w_elig_i),
        .eligible_d (w_elig_d),
        .lock       (r_lock),
        .locked_gnt (r_lock_gnt),
        .last_gnt   (r_last_gnt),
        .gnt        (w_gnt)
    );

    assign w_gnt_d    = (w_gnt == GNT_D);
    assign w_win_elig = w_gnt_d ? w_elig_d : w_elig_i;

    // Command mux.
    assign mem_valid  = w_run && w_idle && w_win_elig;
    assign w_accept   = mem_valid && mem_ready;
    assign mem_addr   = w_gnt_d ? dmem_addr : imem_addr;
    assign mem_size   = w_gnt_d ? dmem_size : imem_size;
    assign mem_cmd    = w_gnt_d ? dmem_cmd  : CMD_RD;
    assign mem_w_valid = mem_valid && w_gnt_d && (dmem_cmd == CMD_WR);
    assign mem_w_strb = dmem_w_strb;
    assign mem_w_data = dmem_w_data;

    assign imem_ready   = w_accept && !w_gnt_d;
    assign dmem_ready   = w_accept && w_gnt_d;
    assign dmem_w_ready = dmem_ready && (dmem_cmd == CMD_WR);
    assign dmem_w_resp  = dmem_w_ready && mem_w_resp;

    // Read return routing: only the owner of the outstanding read sees it.
    assign mem_r_ready  = w_run && (((r_state == BUSY_I) && imem_r_ready) ||
                                    ((r_state == BUSY_D) && dmem_r_ready));
    assign imem_r_valid = w_run && (r_state == BUSY_I) && mem_r_valid;
    assign dmem_r_valid = w_run && (r_state == BUSY_D) && mem_r_valid;
    assign imem_r_data  = mem_r_data;
    assign dmem_r_data  = mem_r_data;
    assign imem_r_resp  = mem_r_resp;
    assign dmem_r_resp  = mem_r_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lock     <= 1'b0;
            r_lock_gnt <= GNT_I;
            r_last_gnt <= GNT_D;
        end else begin
            case (r_state)
                IDLE: begin
                    // Hold a stalled grant so the other port cannot steal
                    // the command slot mid-handshake.
                    r_lock     <= mem_valid && !mem_ready;
                    r_lock_gnt <= w_gnt;
                    if (w_accept) begin
                        r_last_gnt <= w_gnt;
                        if (mem_cmd == CMD_RD) begin
                            r_state <= w_gnt_d ? BUSY_D : BUSY_I;
                        end
                    end
                end
                BUSY_I: begin
                    if (mem_r_valid && imem_r_ready) begin
                        r_state <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (mem_r_valid && dmem_r_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [31:0] FIRST_ADDR  = 32'h100;
    localparam logic [31:0] SECOND_ADDR = 32'h200;
`else
    localparam logic [31:0] FIRST_ADDR  = 32'h200;
    localparam logic [31:0] SECOND_ADDR = 32'h100;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] imem_addr;
    logic [1:0]    imem_size;
    logic          imem_valid, imem_ready, imem_r_ready, imem_r_valid, imem_r_resp;
    logic [DW-1:0] imem_r_data;
    logic [AW-1:0] dmem_addr;
    logic          dmem_cmd;
    logic [1:0]    dmem_size;
    logic          dmem_valid, dmem_ready, dmem_r_ready, dmem_r_valid, dmem_r_resp;
    logic [DW-1:0] dmem_r_data;
    logic          dmem_w_valid, dmem_w_ready, dmem_w_resp;
    logic [SW-1:0] dmem_w_strb;
    logic [DW-1:0] dmem_w_data;
    logic [AW-1:0] mem_addr;
    logic          mem_cmd;
    logic [1:0]    mem_size;
    logic          mem_valid, mem_ready, mem_r_ready, mem_r_valid, mem_r_resp;
    logic [DW-1:0] mem_r_data;
    logic          mem_w_valid, mem_w_ready, mem_w_resp;
    logic [SW-1:0] mem_w_strb;
    logic [DW-1:0] mem_w_data;

    assign mem_w_ready = mem_ready;

    mem_port_arbiter #(.p_ADDR_BITS(AW), .p_DATA_BITS(DW), .p_STRB_BITS(SW)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_size(imem_size), .imem_valid(imem_valid),
        .imem_ready(imem_ready), .imem_r_ready(imem_r_ready), .imem_r_valid(imem_r_valid),
        .imem_r_data(imem_r_data), .imem_r_resp(imem_r_resp),
        .dmem_addr(dmem_addr), .dmem_cmd(dmem_cmd), .dmem_size(dmem_size),
        .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_r_ready(dmem_r_ready),
        .dmem_r_valid(dmem_r_valid), .dmem_r_data(dmem_r_data), .dmem_r_resp(dmem_r_resp),
        .dmem_w_valid(dmem_w_valid), .dmem_w_ready(dmem_w_ready), .dmem_w_strb(dmem_w_strb),
        .dmem_w_data(dmem_w_data), .dmem_w_resp(dmem_w_resp),
        .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_size(mem_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_r_ready(mem_r_ready),
        .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data), .mem_r_resp(mem_r_resp),
        .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready), .mem_w_strb(mem_w_strb),
        .mem_w_data(mem_w_data), .mem_w_resp(mem_w_resp)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the outstanding read (0 none, 1 imem, 2 dmem),
    // a held grant, and the last served port.
    int m_owner     = 0;
    bit m_lock      = 1'b0;
    int m_lock_port = 1;
    int m_last      = 2;

    int          e_win;
    logic        e_mvalid, e_iready, e_dready, e_dwready, e_wvalid, e_dwresp;
    logic        e_mrready, e_irv, e_drv, e_cmd;
    logic [31:0] e_addr;
    logic [1:0]  e_size;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic predict();
        bit el_i, el_d;
        e_win = 1; e_mvalid = 0; e_iready = 0; e_dready = 0; e_dwready = 0;
        e_wvalid = 0; e_dwresp = 0; e_mrready = 0; e_irv = 0; e_drv = 0;
        e_cmd = 0; e_addr = '0; e_size = '0;
        el_i = imem_valid;
        el_d = dmem_valid && (!dmem_cmd || dmem_w_valid);
        if (m_owner == 0) begin
            if (m_lock) e_win = m_lock_port;
`ifdef ARB_ROUND_ROBIN_EN
            else if (el_i && el_d) e_win = (m_last == 2) ? 1 : 2;
`endif
            else e_win = el_d ? 2 : 1;
            e_mvalid  = (e_win == 1) ? el_i : el_d;
            e_addr    = (e_win == 1) ? imem_addr : dmem_addr;
            e_size    = (e_win == 1) ? imem_size : dmem_size;
            e_cmd     = (e_win == 1) ? 1'b0 : dmem_cmd;
            e_iready  = (e_win == 1) && e_mvalid && mem_ready;
            e_dready  = (e_win == 2) && e_mvalid && mem_ready;
            e_wvalid  = (e_win == 2) && e_mvalid && dmem_cmd;
            e_dwready = e_dready && dmem_cmd;
            e_dwresp  = e_dwready && mem_w_resp;
        end else if (m_owner == 1) begin
            e_mrready = imem_r_ready;
            e_irv     = mem_r_valid;
        end else begin
            e_mrready = dmem_r_ready;
            e_drv     = mem_r_valid;
        end
        if (rst) begin
            e_mvalid = 0; e_iready = 0; e_dready = 0; e_dwready = 0; e_wvalid = 0;
            e_dwresp = 0; e_mrready = 0; e_irv = 0; e_drv = 0;
        end
    endtask

    task automatic check_outputs();
        chk("mem_valid", mem_valid, e_mvalid);
        chk("imem_ready", imem_ready, e_iready);
        chk("dmem_ready", dmem_ready, e_dready);
        chk("dmem_w_ready", dmem_w_ready, e_dwready);
        chk("mem_w_valid", mem_w_valid, e_wvalid);
        chk("mem_r_ready", mem_r_ready, e_mrready);
        chk("imem_r_valid", imem_r_valid, e_irv);
        chk("dmem_r_valid", dmem_r_valid, e_drv);
        chk("imem_r_data", imem_r_data, mem_r_data);
        chk("dmem_r_data", dmem_r_data, mem_r_data);
        if (e_mvalid) begin
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_size", mem_size, e_size);
            chk("mem_cmd", mem_cmd, e_cmd);
        end
        if (e_wvalid) begin
            chk("mem_w_strb", mem_w_strb, dmem_w_strb);
            chk("mem_w_data", mem_w_data, dmem_w_data);
        end
        if (e_dwready) chk("dmem_w_resp", dmem_w_resp, e_dwresp);
        if (e_irv) chk("imem_r_resp", imem_r_resp, mem_r_resp);
        if (e_drv) chk("dmem_r_resp", dmem_r_resp, mem_r_resp);
    endtask

    task automatic update_model();
        if (rst) begin
            m_owner = 0; m_lock = 0; m_last = 2;
        end else if (m_owner == 0) begin
            if (e_mvalid && mem_ready) begin
                m_lock = 0;
                m_last = e_win;
                if (!(e_win == 2 && dmem_cmd)) m_owner = e_win;
            end else begin
                m_lock      = e_mvalid;
                m_lock_port = e_win;
            end
        end else if (m_owner == 1) begin
            if (mem_r_valid && imem_r_ready) m_owner = 0;
        end else begin
            if (mem_r_valid && dmem_r_ready) m_owner = 0;
        end
    endtask

    task automatic settle();
        #1;
        predict();
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic idle_inputs();
        rst = 0;
        imem_addr = '0; imem_size = 2'd2; imem_valid = 0; imem_r_ready = 0;
        dmem_addr = '0; dmem_cmd = 0; dmem_size = 2'd2; dmem_valid = 0; dmem_r_ready = 0;
        dmem_w_valid = 0; dmem_w_strb = '0; dmem_w_data = '0;
        mem_ready = 0; mem_r_valid = 0; mem_r_data = '0; mem_r_resp = 0; mem_w_resp = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] acc_addr[$];
        int          acc_idx[$];

        idle_inputs();
        rst = 1;
        @(negedge clk);

        // Reset: everything quiet even with all inputs asserted.
        imem_valid = 1; dmem_valid = 1; mem_ready = 1; mem_r_valid = 1;
        imem_r_ready = 1; dmem_r_ready = 1;
        settle();
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_imem_ready", imem_ready, 1'b0);
        tick();
        cycle();
        idle_inputs();
        cycle();

        // imem read, data two cycles later.
        imem_valid = 1; imem_addr = 32'h100; mem_ready = 1;
        settle();
        chk("t1_addr", mem_addr, 32'h100);
        tick();
        imem_valid = 0; mem_ready = 0;
        cycle();
        mem_r_valid = 1; mem_r_data = 32'hDEADBEEF; imem_r_ready = 1;
        settle();
        chk("t1_rvalid", imem_r_valid, 1'b1);
        chk("t1_rdata", imem_r_data, 32'hDEADBEEF);
        chk("t1_dmem_rvalid", dmem_r_valid, 1'b0);
        tick();
        settle();
        chk("t1_idle_rvalid", imem_r_valid, 1'b0);
        tick();
        idle_inputs();

        // Contention between imem and dmem reads.
        imem_valid = 1; imem_addr = 32'h100;
        dmem_valid = 1; dmem_cmd = 0; dmem_addr = 32'h200;
        mem_ready = 1; mem_r_valid = 1; imem_r_ready = 1; dmem_r_ready = 1;
        for (int i = 0; i < 6; i++) begin
            settle();
            if (mem_valid && mem_ready) begin
                acc_addr.push_back(mem_addr);
                acc_idx.push_back(i);
            end
            tick();
            if (e_iready) imem_valid = 0;
            if (e_dready) dmem_valid = 0;
        end
        chk("t2_count", acc_addr.size(), 2);
        if (acc_addr.size() == 2) begin
            chk("t2_first", acc_addr[0], FIRST_ADDR);
            chk("t2_second", acc_addr[1], SECOND_ADDR);
            chk("t2_gap", acc_idx[1] - acc_idx[0], 2);
        end
        idle_inputs();
        cycle();

        // Back-to-back writes.
        dmem_valid = 1; dmem_cmd = 1; dmem_w_valid = 1; dmem_addr = 32'h300;
        dmem_w_strb = 4'b0011; dmem_w_data = 32'h12345678; mem_ready = 1;
        settle();
        chk("t3_wvalid", mem_w_valid, 1'b1);
        chk("t3_strb", mem_w_strb, 4'b0011);
        chk("t3_data", mem_w_data, 32'h12345678);
        chk("t3_wready", dmem_w_ready, 1'b1);
        tick();
        dmem_addr = 32'h304; dmem_w_data = 32'hCAFEF00D; mem_w_resp = 1;
        settle();
        chk("t3_wready2", dmem_w_ready, 1'b1);
        chk("t3_wresp2", dmem_w_resp, 1'b1);
        tick();
        dmem_w_valid = 0;
        settle();
        chk("t3_nodata", mem_valid, 1'b0);
        tick();
        idle_inputs();

        // Grant lock while the controller stalls.
        imem_valid = 1; imem_addr = 32'h400;
        settle();
        chk("t4_addr0", mem_addr, 32'h400);
        tick();
        dmem_valid = 1; dmem_cmd = 0; dmem_addr = 32'h500;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t4_addr_held", mem_addr, 32'h400);
            chk("t4_dready", dmem_ready, 1'b0);
            tick();
        end
        mem_ready = 1;
        settle();
        chk("t4_addr_acc", mem_addr, 32'h400);
        chk("t4_iready", imem_ready, 1'b1);
        tick();
        imem_valid = 0; mem_r_valid = 1; imem_r_ready = 1; dmem_r_ready = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (e_dready) dmem_valid = 0;
        end
        idle_inputs();
        cycle();

        // dmem read held in BUSY_D until its r_ready.
        dmem_valid = 1; dmem_cmd = 0; dmem_addr = 32'h600; mem_ready = 1;
        cycle();
        dmem_valid = 0; mem_ready = 0; mem_r_valid = 1; mem_r_data = 32'h0BADF00D;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t5_drv", dmem_r_valid, 1'b1);
            chk("t5_mrready", mem_r_ready, 1'b0);
            tick();
        end
        dmem_r_ready = 1;
        settle();
        chk("t5_done_rready", mem_r_ready, 1'b1);
        tick();
        settle();
        chk("t5_idle_drv", dmem_r_valid, 1'b0);
        tick();
        idle_inputs();

        // Reset while an imem read is outstanding.
        imem_valid = 1; imem_addr = 32'h700; mem_ready = 1;
        cycle();
        imem_valid = 0; rst = 1; mem_r_valid = 1; imem_r_ready = 1;
        settle();
        chk("t6_rst_irv", imem_r_valid, 1'b0);
        chk("t6_rst_rready", mem_r_ready, 1'b0);
        tick();
        rst = 0;
        settle();
        chk("t6_stale_irv", imem_r_valid, 1'b0);
        chk("t6_stale_rready", mem_r_ready, 1'b0);
        tick();
        idle_inputs();

        // Randomized traffic with protocol-legal requesters.
        for (int i = 0; i < 800; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            mem_ready    = ($urandom_range(0, 9) < 7);
            mem_r_valid  = $urandom_range(0, 1);
            mem_r_data   = $urandom;
            mem_r_resp   = $urandom_range(0, 1);
            mem_w_resp   = $urandom_range(0, 1);
            imem_r_ready = $urandom_range(0, 1);
            dmem_r_ready = $urandom_range(0, 1);
            cycle();
            if (!imem_valid || e_iready) begin
                imem_valid = $urandom_range(0, 1);
                imem_addr  = $urandom;
                imem_size  = 2'($urandom_range(0, 3));
            end
            if (!dmem_valid || e_dready) begin
                dmem_valid   = $urandom_range(0, 1);
                dmem_addr    = $urandom;
                dmem_size    = 2'($urandom_range(0, 3));
                dmem_cmd     = $urandom_range(0, 1);
                dmem_w_valid = dmem_cmd;
                dmem_w_strb  = 4'($urandom_range(0, 15));
                dmem_w_data  = $urandom;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one downstream memory port between the core's imem (read-only) and dmem (read/write) request ports.
- Protocol is identical on all sides: valid/ready command channel, r_valid/r_ready read return, w_valid/w_ready write data.
- Sits between the core and a single-port memory controller. At most one read is outstanding at a time.
- Adds no command latency: the arbitration mux is combinational, and state is held only for grant lock and read ownership.

Parameters:
p_ADDR_BITS, 32, address width
p_DATA_BITS, 32, data width
p_STRB_BITS, p_DATA_BITS/8, write strobe width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
imem_addr  in  p_ADDR_BITS  imem address (imem always reads)
imem_size  in  2  access size
imem_valid  in  1  imem command valid
imem_ready  out  1  imem command accepted
imem_r_ready  in  1  imem accepts read data
imem_r_valid  out  1  imem read data valid
imem_r_data  out  p_DATA_BITS  read data (broadcast of mem_r_data)
imem_r_resp  out  1  read error flag, qualified by imem_r_valid
dmem_addr  in  p_ADDR_BITS  dmem address
dmem_cmd  in  1  0=read, 1=write
dmem_size  in  2  access size
dmem_valid  in  1  dmem command valid
dmem_ready  out  1  dmem command accepted
dmem_r_ready / dmem_r_valid / dmem_r_data / dmem_r_resp  as imem, for dmem
dmem_w_valid  in  1  write data valid; must accompany a write command
dmem_w_ready  out  1  write data accepted (equals dmem_ready on writes)
dmem_w_strb  in  p_STRB_BITS  byte strobes
dmem_w_data  in  p_DATA_BITS  write data
dmem_w_resp  out  1  write error flag, qualified by the write accept cycle
mem_*  master port to the memory controller: the same 14 signals as dmem_*, directions reversed

Behaviour:
- States: IDLE, BUSY_I (imem read outstanding), BUSY_D (dmem read outstanding). Reset state is IDLE.
- Reset: while rst=1, every ready/valid output is forced to 0 and the lock is cleared. Reset mid-read abandons the read; any later mem_r_valid is ignored because mem_r_ready=0 in IDLE.
- IDLE, pick: a requester is eligible when its valid=1. A dmem write is eligible only if dmem_w_valid=1 as well.
- Priority: fixed dmem > imem.
- The winner's addr, cmd, size, strb and data drive mem_*. imem forces mem_cmd=0 and mem_w_valid=0.
- mem_valid = winner eligible. winner_ready = mem_ready. The loser's ready is 0.
- Lock: if mem_valid=1 and mem_ready=0, the grant is registered and held until acceptance, even if the other port becomes eligible. A requester must not drop valid before ready.
- Accept (mem_valid && mem_ready), read: go to BUSY_I or BUSY_D and clear the lock.
- Accept, write: stay IDLE. The write is complete in that cycle, and dmem_w_resp = mem_w_resp.
- BUSY_x:
  - mem_valid=0 and both command readies are 0.
  - mem_r_ready = x_r_ready. x_r_valid = mem_r_valid. The other port's r_valid=0.
  - On mem_r_valid && x_r_ready, go to IDLE next cycle.
- Throughput: 1-cycle bubble after each read completes. Back-to-back writes are possible every cycle.
- Simultaneous imem and dmem valid in IDLE: the priority rule decides; the loser waits with valid held.
- mem_r_valid in IDLE is dropped: mem_r_ready=0 and no r_valid is routed.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: a last-grant register (reset value = dmem, so imem wins first) updates on each accepted command. On contention, the port not granted last wins; lock rules are unchanged.
- Undefined: fixed dmem > imem priority and no last-grant register.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, BUSY_I, BUSY_D}
  - grant enum {GNT_I, GNT_D}
  - localparams CMD_RD=1'b0, CMD_WR=1'b1
- Sub-module mem_arb_pick: combinational picker with inputs eligible_i, eligible_d, lock, locked_gnt, last_gnt and output gnt. It is the only place ARB_ROUND_ROBIN_EN is tested.

Test Plan:
- imem read 0x100, mem_ready=1, mem_r_valid after 2 cycles with data 0xDEADBEEF -> imem_r_valid=1 with that data; dmem_r_valid stays 0; IDLE next cycle.
- imem read and dmem read 0x200 both valid in the same cycle -> macro off: dmem wins, imem granted after dmem's r handshake plus 1 cycle. Macro on: imem first, then dmem.
- dmem write 0x300, strb 4'b0011, data 0x12345678, mem_ready=1 -> mem_w_valid=1 with the same strb and data, dmem_w_ready=1, state stays IDLE; a second write next cycle is also accepted.
- imem valid with mem_ready=0 for 3 cycles, dmem valid rises at cycle 1 -> grant stays imem until accepted; mem_addr stable throughout.
- dmem read accepted, then imem_r_ready=0 and mem_r_valid=1 for 2 cycles with dmem_r_ready=0 -> held in BUSY_D; completes when dmem_r_ready=1.
- rst=1 while in BUSY_I -> next cycle IDLE, all readies and valids 0 during reset; a stale mem_r_valid after reset is not routed.
